seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter SHIFT_STEP, default 8, maximum shift distance per cycle; power of two, 1..XLEN.
REQ-003 SHALL use one clock and a synchronous, active-high reset. Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
REQ-004 SHALL have the following request ports:
- req_valid   in   1     request present.
- req_ready   out  1     request accepted this cycle when high together with req_valid.
- req_insn30  in   1     selects SUB in ADDSUB and SRA in SR_.
- req_funct3  in   3     0 ADDSUB, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SR_, 6 OR, 7 AND.
- req_w       in   1     32-bit word operation; ignored when XLEN=32.
- req_op1     in   XLEN  first operand.
- req_op2     in   XLEN  second operand or shift amount.
REQ-005 SHALL have the following response and status ports:
- res_valid   out  1     result present.
- res_ready   in   1     consumer takes the result when high together with res_valid.
- res_result  out  XLEN  result, stable while res_valid is high.
- busy        out  1     high while the block is in state SHIFT.

Function
REQ-006 SHALL implement states IDLE and SHIFT; the output register (res_valid, res_result) is independent of state.
REQ-007 SHALL drive req_ready = (state==IDLE) && (!res_valid || res_ready), allowing back-to-back operations with no bubble.
REQ-008 SHALL, on acceptance of ADDSUB, SLT, SLTU, XOR, OR or AND, register the result and raise res_valid on the next cycle (latency 1).
REQ-009 SHALL compute ADDSUB as op1+op2, or op1-op2 when req_insn30=1, modulo 2^XLEN.
REQ-010 SHALL compute SLT as a signed compare and SLTU as an unsigned compare, giving 1 or 0 zero-extended; req_insn30 has no effect on either.
REQ-011 SHALL take the shift amount as op2[4:0] when req_w=1 and XLEN=64, otherwise as op2[log2(XLEN)-1:0].
REQ-012 SHALL perform SR_ arithmetically when req_insn30=1 and logically otherwise.
REQ-013 SHALL, for req_w=1 SR_, shift only op1[31:0], filling with op1[31] if arithmetic and with 0 if logical.
REQ-014 SHALL perform shifts iteratively:
- the accepting edge shifts by min(SHIFT_STEP, amt) and enters SHIFT if amount remains;
- each further edge shifts by min(SHIFT_STEP, remaining);
- the block returns to IDLE and raises res_valid on the edge where remaining reaches 0;
- latency = max(1, ceil(amt/SHIFT_STEP)) cycles.
REQ-015 SHALL, when req_w=1 and XLEN=64, sign-extend bit 31 of every final result into bits 63:32.
REQ-016 SHALL hold res_valid and res_result unchanged while res_valid=1 and res_ready=0.
REQ-017 SHALL clear res_valid on a cycle with res_valid && res_ready unless a new result is produced on the same edge, in which case res_valid stays high with the new res_result.
REQ-018 SHALL ignore req_* inputs whenever req_ready=0; operands are captured only at acceptance.

Reset
REQ-019 SHALL, on reset, set state=IDLE, res_valid=0, busy=0 and res_result=0 on the next edge, abandoning any shift in progress with no result delivered.
REQ-020 SHALL hold req_ready=0 during any cycle with reset=1.

Configuration
REQ-021 SHALL, with macro SEQ_ALU_BARREL_SHIFT_EN defined, perform every shift in one cycle (latency 1), never enter SHIFT, hold busy=0 and ignore SHIFT_STEP.
REQ-022 SHALL, without SEQ_ALU_BARREL_SHIFT_EN, use the iterative shifter of REQ-014; results SHALL be bit-identical in both builds.

Verification
REQ-023 XLEN=64, SUB op1=5, op2=7, res_ready=1 -> res_result=0xFFFFFFFFFFFFFFFE one cycle after acceptance; req_ready high every cycle.
REQ-024 XLEN=64, SHIFT_STEP=8, SRA op1=0x8000000000000000, op2=20 -> busy for 2 cycles; res_result=0xFFFFF80000000000 3 cycles after acceptance.
REQ-025 XLEN=64, w=1 SLL op1=1, op2=31 -> res_result=0xFFFFFFFF80000000; w=1 SRL op1=0xFFFFFFFF80000000, op2=4 -> res_result=0x0000000008000000.
REQ-026 SLT op1=-1, op2=1 -> 1; SLTU with the same operands -> 0; issued back-to-back with res_ready=0 on cycle 2 -> first result held and req_ready=0 until drained.
REQ-027 Reset asserted on the 2nd cycle of SLL op2=63 with SHIFT_STEP=4 -> res_valid never rises for that operation; next cycle state=IDLE and req_ready=1.
REQ-028 SLL op2=0 -> latency 1 with res_result=op1; repeat REQ-024 with SEQ_ALU_BARREL_SHIFT_EN defined -> latency 1, busy=0, same res_result.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu : sequential integer ALU for RV-style register/register operations.
//
// Purpose
//    Executes ADD/SUB, SLT, SLTU, XOR, OR and AND with a fixed latency of one
//    cycle. Executes SLL, SRL and SRA either iteratively, at most SHIFT_STEP
//    bit positions per cycle, or in one cycle through a barrel shifter.
//    The result sits in an output register with a valid/ready handshake.
//    The handshake lets a new operation be accepted on the same edge that
//    the consumer drains the previous result.
//
// Configuration
//    SEQ_ALU_BARREL_SHIFT_EN : when defined, every shift finishes in one cycle.
//                              The SHIFT state is never entered and SHIFT_STEP
//                              is unused. Results are identical in both builds.
//
// Parameters
//    XLEN       : datapath width, 32 or 64.
//    SHIFT_STEP : maximum shift distance per cycle, a power of two in 1..XLEN.
//
// Ports
//    clock      in   sole clock, rising edge
//    reset      in   synchronous, active-high
//    req_valid  in   request present
//    req_ready  out  request accepted when high together with req_valid
//    req_insn30 in   SUB in ADDSUB, arithmetic in SR_
//    req_funct3 in   0 ADDSUB, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SR_, 6 OR, 7 AND
//    req_w      in   32-bit word operation (XLEN=64 only)
//    req_op1    in   first operand
//    req_op2    in   second operand or shift amount
//    res_valid  out  result present
//    res_ready  in   consumer takes the result
//    res_result out  result, stable while res_valid is high
//    busy       out  high while an iterative shift is in progress
module seq_alu #(
   parameter int XLEN       = 64,
   parameter int SHIFT_STEP = 8
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_insn30,
   input  logic [2:0]      req_funct3,
   input  logic            req_w,
   input  logic [XLEN-1:0] req_op1,
   input  logic [XLEN-1:0] req_op2,
   output logic            res_valid,
   input  logic            res_ready,
   output logic [XLEN-1:0] res_result,
   output logic            busy
);

   localparam int LOGX = $clog2(XLEN);
   // Shift amounts carry one extra bit, so that SHIFT_STEP == XLEN still fits.
   localparam int AW = LOGX + 1;
   localparam logic [AW-1:0] STEP = AW'(SHIFT_STEP);

   typedef enum logic {IDLE, SHIFT} state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] shVal_q, shVal_d;
   logic [AW-1:0]   shRem_q, shRem_d;
   logic            shLeft_q, shLeft_d;
   logic            shArith_q, shArith_d;
   logic            shWord_q, shWord_d;
   logic            resValid_q, resValid_d;
   logic [XLEN-1:0] resResult_q, resResult_d;

   logic            wordOp;
   logic            isShift;
   logic            isLeft;
   logic            fire;
   logic [AW-1:0]   amt;
   logic [AW-1:0]   accStep;
   logic [AW-1:0]   accRem;
   logic [XLEN-1:0] shLoad;
   logic [XLEN-1:0] accShifted;
   logic [XLEN-1:0] aluResult;
   logic [AW-1:0]   iterStep;
   logic [AW-1:0]   iterRem;
   logic [XLEN-1:0] iterShifted;

   function automatic logic [XLEN-1:0] shiftBy(input logic [XLEN-1:0] v,
                                                input logic [AW-1:0]   n,
                                                input logic            left,
                                                input logic            arith);
      logic [XLEN-1:0] r;
      if (left) begin
         r = v << n;
      end else if (arith) begin
         r = XLEN'($signed(v) >>> n);
      end else begin
         r = v >> n;
      end
      return r;
   endfunction

   // Word results are sign-extended from bit 31. With XLEN=32 the loop is empty.
   function automatic logic [XLEN-1:0] wordExt(input logic [XLEN-1:0] v,
                                                input logic            en);
      logic [XLEN-1:0] r;
      r = v;
      if (en) begin
         for (int i = 32; i < XLEN; i++) begin
            r[i] = v[31];
         end
      end
      return r;
   endfunction

   assign wordOp  = (XLEN == 64) ? req_w : 1'b0;
   assign isShift = (req_funct3 == 3'd1) || (req_funct3 == 3'd5);
   assign isLeft  = (req_funct3 == 3'd1);

   // The handshake is closed during reset. A new request may enter only when
   // the output register is empty or is being drained on this edge.
   assign req_ready  = (state_q == IDLE) && (!resValid_q || res_ready) && !reset;
   assign fire       = req_valid && req_ready;
   assign res_valid  = resValid_q;
   assign res_result = resResult_q;
   assign busy       = (state_q == SHIFT);

   // The shift amount is decoded and the operand preloaded. A word right
   // shift sees only op1[31:0], widened with the fill bit that the shift
   // itself would insert. The full-width shifter then produces the correct
   // low 32 bits.
   always_comb begin
      amt = AW'(req_op2[LOGX-1:0]);
      if (wordOp) begin
         amt = AW'(req_op2[4:0]);
      end
      shLoad = req_op1;
      if (wordOp && !isLeft) begin
         for (int i = 32; i < XLEN; i++) begin
            shLoad[i] = req_insn30 & req_op1[31];
         end
      end
   end

   // The accepting edge shifts as far as it is allowed. The iterative build
   // caps that distance at STEP; the barrel build completes the shift at once.
   always_comb begin
`ifdef SEQ_ALU_BARREL_SHIFT_EN
      accStep = amt;
`else
      accStep = (amt > STEP) ? STEP : amt;
`endif
      accRem     = amt - accStep;
      accShifted = shiftBy(shLoad, accStep, isLeft, req_insn30);
   end

   // These are the single-cycle results. Shift opcodes fall through to the
   // first shift step, which is already the final value when nothing remains.
   always_comb begin
      aluResult = accShifted;
      case (req_funct3)
         3'd0:    aluResult = req_insn30 ? (req_op1 - req_op2) : (req_op1 + req_op2);
         3'd2:    aluResult = {{(XLEN-1){1'b0}}, ($signed(req_op1) < $signed(req_op2))};
         3'd3:    aluResult = {{(XLEN-1){1'b0}}, (req_op1 < req_op2)};
         3'd4:    aluResult = req_op1 ^ req_op2;
         3'd6:    aluResult = req_op1 | req_op2;
         3'd7:    aluResult = req_op1 & req_op2;
         default: aluResult = accShifted;
      endcase
   end

   // This is one further step of an iterative shift that is in progress.
   always_comb begin
      iterStep    = (shRem_q > STEP) ? STEP : shRem_q;
      iterRem     = shRem_q - iterStep;
      iterShifted = shiftBy(shVal_q, iterStep, shLeft_q, shArith_q);
   end

   // Next-state logic. The output register drains when the consumer takes the
   // result. It reloads whenever an operation completes, including on a drain
   // edge, so that back-to-back results leave no gap.
   always_comb begin
      state_d     = state_q;
      shVal_d     = shVal_q;
      shRem_d     = shRem_q;
      shLeft_d    = shLeft_q;
      shArith_d   = shArith_q;
      shWord_d    = shWord_q;
      resValid_d  = resValid_q && !res_ready;
      resResult_d = resResult_q;
      case (state_q)
         IDLE: begin
            if (fire) begin
               if (isShift && (accRem != '0)) begin
                  state_d   = SHIFT;
                  shVal_d   = accShifted;
                  shRem_d   = accRem;
                  shLeft_d  = isLeft;
                  shArith_d = req_insn30;
                  shWord_d  = wordOp;
               end else begin
                  resValid_d  = 1'b1;
                  resResult_d = wordExt(aluResult, wordOp);
               end
            end
         end
         SHIFT: begin
            if (iterRem == '0) begin
               state_d     = IDLE;
               resValid_d  = 1'b1;
               resResult_d = wordExt(iterShifted, shWord_q);
            end else begin
               shVal_d = iterShifted;
               shRem_d = iterRem;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register. Reset abandons any shift in progress without a result.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         shVal_q     <= '0;
         shRem_q     <= '0;
         shLeft_q    <= 1'b0;
         shArith_q   <= 1'b0;
         shWord_q    <= 1'b0;
         resValid_q  <= 1'b0;
         resResult_q <= '0;
      end else begin
         state_q     <= state_d;
         shVal_q     <= shVal_d;
         shRem_q     <= shRem_d;
         shLeft_q    <= shLeft_d;
         shArith_q   <= shArith_d;
         shWord_q    <= shWord_d;
         resValid_q  <= resValid_d;
         resResult_q <= resResult_d;
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu : self-checking bench for seq_alu with XLEN=64, SHIFT_STEP=8.
// The reference model computes each result directly from the operation's
// arithmetic definition. It computes the latency from the shift amount.
module tb_seq_alu;

   localparam int XLEN = 64;
   localparam int STEP = 8;

   logic            clock = 1'b0;
   logic            reset;
   logic            req_valid;
   logic            req_ready;
   logic            req_insn30;
   logic [2:0]      req_funct3;
   logic            req_w;
   logic [XLEN-1:0] req_op1;
   logic [XLEN-1:0] req_op2;
   logic            res_valid;
   logic            res_ready;
   logic [XLEN-1:0] res_result;
   logic            busy;

   int total = 0;
   int bad   = 0;

   seq_alu #(.XLEN(XLEN), .SHIFT_STEP(STEP)) dut (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_insn30 (req_insn30),
      .req_funct3 (req_funct3),
      .req_w      (req_w),
      .req_op1    (req_op1),
      .req_op2    (req_op2),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_result (res_result),
      .busy       (busy)
   );

   always #5 clock = ~clock;

   // Reference result, taken directly from the operation definitions.
   function automatic logic [63:0] refResult(input logic i30, input logic [2:0] f3,
                                             input logic w, input logic [63:0] a,
                                             input logic [63:0] b);
      logic [63:0] r;
      logic [31:0] lo;
      int          amt;
      amt = w ? int'(b[4:0]) : int'(b[5:0]);
      lo  = a[31:0];
      r   = '0;
      case (f3)
         3'd0: r = i30 ? (a - b) : (a + b);
         3'd1: r = a << amt;
         3'd2: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
         3'd3: r = (a < b) ? 64'd1 : 64'd0;
         3'd4: r = a ^ b;
         3'd5: begin
            if (w) begin
               if (i30) lo = $signed(lo) >>> amt;
               else     lo = lo >> amt;
               r = {32'b0, lo};
            end else begin
               if (i30) r = $signed(a) >>> amt;
               else     r = a >> amt;
            end
         end
         3'd6: r = a | b;
         default: r = a & b;
      endcase
      if (w) r = {{32{r[31]}}, r[31:0]};
      return r;
   endfunction

   // Reference latency in cycles, counted from the accepting edge.
   function automatic int refLatency(input logic [2:0] f3, input logic w,
                                     input logic [63:0] b);
      int amt;
      amt = w ? int'(b[4:0]) : int'(b[5:0]);
      if (f3 != 3'd1 && f3 != 3'd5) return 1;
`ifdef SEQ_ALU_BARREL_SHIFT_EN
      return 1;
`else
      if (amt == 0) return 1;
      return (amt + STEP - 1) / STEP;
`endif
   endfunction

   // Drives one request with res_ready=1. Returns the result, the latency and
   // the number of busy cycles.
   task automatic applyStimulus(input logic i30, input logic [2:0] f3, input logic w,
                                input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] res, output int lat,
                                output int busyCnt);
      int guard;
      req_insn30 = i30;
      req_funct3 = f3;
      req_w      = w;
      req_op1    = a;
      req_op2    = b;
      req_valid  = 1'b1;
      res_ready  = 1'b1;
      #1;
      guard = 0;
      while (!req_ready && guard < 100) begin
         @(posedge clock); #1;
         guard++;
      end
      @(posedge clock); #1;
      req_valid = 1'b0;
      lat       = 1;
      busyCnt   = 0;
      while (!res_valid && lat < 200) begin
         if (busy) busyCnt++;
         @(posedge clock); #1;
         lat++;
      end
      res = res_result;
   endtask

   task automatic idleCycle();
      req_valid = 1'b0;
      res_ready = 1'b1;
      @(posedge clock); #1;
   endtask

   task automatic test_reset();
      reset      = 1'b1;
      req_valid  = 1'b0;
      res_ready  = 1'b1;
      req_insn30 = 1'b0;
      req_funct3 = 3'd0;
      req_w      = 1'b0;
      req_op1    = '0;
      req_op2    = '0;
      repeat (3) @(posedge clock);
      #1;
      total++;
      if (res_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b expected 0", res_valid); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      total++;
      if (res_result !== 64'd0) begin bad++; $display("[TB] FAIL reset_result: got %h expected 0", res_result); end
      total++;
      if (req_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready_low: got %b expected 0", req_ready); end
      reset = 1'b0;
      #1;
      total++;
      if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready_high: got %b expected 1", req_ready); end
   endtask

   // The first operation is SUB 5-7; random ADD/SUB operations follow while
   // req_valid stays high. One result must appear per cycle.
   task automatic test_addsub();
      logic [63:0] expV;
      res_ready  = 1'b1;
      req_funct3 = 3'd0;
      req_w      = 1'b0;
      req_insn30 = 1'b1;
      req_op1    = 64'd5;
      req_op2    = 64'd7;
      req_valid  = 1'b1;
      #1;
      for (int k = 0; k < 6; k++) begin
         expV = refResult(req_insn30, 3'd0, req_w, req_op1, req_op2);
         total++;
         if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL addsub_ready[%0d]: got %b expected 1", k, req_ready); end
         @(posedge clock); #1;
         total++;
         if (res_valid !== 1'b1 || res_result !== expV) begin
            bad++;
            $display("[TB] FAIL addsub_result[%0d]: got v=%b %h expected v=1 %h", k, res_valid, res_result, expV);
         end
         req_insn30 = 1'($urandom_range(0, 1));
         req_w      = 1'($urandom_range(0, 1));
         req_op1    = {$urandom, $urandom};
         req_op2    = {$urandom, $urandom};
         #1;
      end
      idleCycle();
   endtask

   task automatic test_shift_directed();
      logic [63:0] res;
      int          lat;
      int          bc;
      applyStimulus(1'b1, 3'd5, 1'b0, 64'h8000000000000000, 64'd20, res, lat, bc);
      total++;
      if (res !== 64'hFFFFF80000000000) begin bad++; $display("[TB] FAIL sra20_result: got %h expected fffff80000000000", res); end
      total++;
      if (lat !== refLatency(3'd5, 1'b0, 64'd20)) begin bad++; $display("[TB] FAIL sra20_latency: got %0d expected %0d", lat, refLatency(3'd5, 1'b0, 64'd20)); end
      total++;
      if (bc !== refLatency(3'd5, 1'b0, 64'd20) - 1) begin bad++; $display("[TB] FAIL sra20_busy: got %0d expected %0d", bc, refLatency(3'd5, 1'b0, 64'd20) - 1); end

      applyStimulus(1'b0, 3'd1, 1'b1, 64'd1, 64'd31, res, lat, bc);
      total++;
      if (res !== 64'hFFFFFFFF80000000) begin bad++; $display("[TB] FAIL sllw31_result: got %h expected ffffffff80000000", res); end

      applyStimulus(1'b0, 3'd5, 1'b1, 64'hFFFFFFFF80000000, 64'd4, res, lat, bc);
      total++;
      if (res !== 64'h0000000008000000) begin bad++; $display("[TB] FAIL srlw4_result: got %h expected 0000000008000000", res); end

      applyStimulus(1'b0, 3'd1, 1'b0, 64'h123456789ABCDEF0, 64'hFFFFFFFFFFFFFFC0, res, lat, bc);
      total++;
      if (res !== 64'h123456789ABCDEF0 || lat !== 1) begin
         bad++;
         $display("[TB] FAIL sll0: got %h lat=%0d expected 123456789abcdef0 lat=1", res, lat);
      end
      idleCycle();
   endtask

   // SLT and SLTU are issued back to back. The consumer stalls on the second
   // cycle, so the first result must hold and the second request must wait.
   task automatic test_back_to_back();
      req_insn30 = 1'b1;
      req_funct3 = 3'd2;
      req_w      = 1'b0;
      req_op1    = '1;
      req_op2    = 64'd1;
      req_valid  = 1'b1;
      res_ready  = 1'b1;
      #1;
      @(posedge clock); #1;
      total++;
      if (res_valid !== 1'b1 || res_result !== 64'd1) begin bad++; $display("[TB] FAIL slt_result: got v=%b %h expected v=1 1", res_valid, res_result); end
      req_funct3 = 3'd3;
      res_ready  = 1'b0;
      #1;
      total++;
      if (req_ready !== 1'b0) begin bad++; $display("[TB] FAIL stall_ready: got %b expected 0", req_ready); end
      for (int k = 0; k < 2; k++) begin
         @(posedge clock); #1;
         total++;
         if (res_valid !== 1'b1 || res_result !== 64'd1 || req_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL stall_hold[%0d]: got v=%b r=%b %h expected v=1 r=0 1", k, res_valid, req_ready, res_result);
         end
      end
      res_ready = 1'b1;
      #1;
      total++;
      if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL drain_ready: got %b expected 1", req_ready); end
      @(posedge clock); #1;
      req_valid = 1'b0;
      total++;
      if (res_valid !== 1'b1 || res_result !== 64'd0) begin bad++; $display("[TB] FAIL sltu_result: got v=%b %h expected v=1 0", res_valid, res_result); end
      @(posedge clock); #1;
      total++;
      if (res_valid !== 1'b0) begin bad++; $display("[TB] FAIL drained_valid: got %b expected 0", res_valid); end
   endtask

   // Reset arrives in the cycle after an SLL by 63 is accepted.
   task automatic test_reset_mid_shift();
      int seen;
      req_insn30 = 1'b0;
      req_funct3 = 3'd1;
      req_w      = 1'b0;
      req_op1    = {$urandom, $urandom} | 64'd1;
      req_op2    = 64'd63;
      req_valid  = 1'b1;
      res_ready  = 1'b1;
      #1;
      @(posedge clock); #1;
      req_valid = 1'b0;
`ifndef SEQ_ALU_BARREL_SHIFT_EN
      total++;
      if (busy !== 1'b1 || res_valid !== 1'b0) begin bad++; $display("[TB] FAIL midshift_busy: got busy=%b v=%b expected busy=1 v=0", busy, res_valid); end
`endif
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      total++;
      if (res_valid !== 1'b0 || busy !== 1'b0 || res_result !== 64'd0) begin
         bad++;
         $display("[TB] FAIL midshift_reset: got v=%b busy=%b %h expected v=0 busy=0 0", res_valid, busy, res_result);
      end
      #1;
      total++;
      if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL midshift_ready: got %b expected 1", req_ready); end
      seen = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clock); #1;
         if (res_valid) seen++;
      end
      total++;
      if (seen !== 0) begin bad++; $display("[TB] FAIL midshift_noresult: got %0d valid cycles expected 0", seen); end
   endtask

   task automatic test_random();
      logic [63:0] res;
      logic [63:0] a;
      logic [63:0] b;
      logic [2:0]  f3;
      logic        i30;
      logic        w;
      int          lat;
      int          bc;
      for (int k = 0; k < 60; k++) begin
         f3  = 3'($urandom_range(0, 7));
         i30 = 1'($urandom_range(0, 1));
         w   = 1'($urandom_range(0, 1));
         a   = {$urandom, $urandom};
         b   = {$urandom, $urandom};
         if ($urandom_range(0, 4) == 0) b = a;
         applyStimulus(i30, f3, w, a, b, res, lat, bc);
         checkOutput(k, i30, f3, w, a, b, res, lat, bc);
      end
      idleCycle();
   endtask

   task automatic checkOutput(input int k, input logic i30, input logic [2:0] f3,
                              input logic w, input logic [63:0] a, input logic [63:0] b,
                              input logic [63:0] res, input int lat, input int bc);
      logic [63:0] expV;
      int          expL;
      expV = refResult(i30, f3, w, a, b);
      expL = refLatency(f3, w, b);
      total++;
      if (res !== expV || lat !== expL || bc !== expL - 1) begin
         bad++;
         $display("[TB] FAIL random[%0d] f3=%0d i30=%b w=%b: got %h lat=%0d busy=%0d expected %h lat=%0d busy=%0d",
                  k, f3, i30, w, res, lat, bc, expV, expL, expL - 1);
      end
   endtask

   initial begin
      test_reset();
      test_addsub();
      test_shift_directed();
      test_back_to_back();
      test_reset_mid_shift();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
